// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared state encodings and default sizes for the execution controller
package exec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } exec_state_t;

  localparam int CNT_W_DEF    = 16;
  localparam int DB_DEPTH_DEF = 3;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronise, debounce and edge-detect the single-step button
module btn_debounce
  import exec_pkg::*;
#(
  parameter int DB_DEPTH = DB_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic step_btn,
  output logic step_press
);

  logic                btn_meta;
  logic                btn_sync;
  logic [DB_DEPTH-1:0] hist;
  logic [DB_DEPTH-1:0] hist_next;
  logic                btn_level;
  logic                level_q;

  assign hist_next = {hist[DB_DEPTH-2:0], btn_sync};

  // two-flop synchroniser for the raw asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= step_btn;
      btn_sync <= btn_meta;
    end
  end

  // sample history on each slow tick; level changes only on a unanimous window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist      <= '0;
      btn_level <= 1'b0;
    end else if (tick) begin
      hist <= hist_next;
      if (&hist_next) begin
        btn_level <= 1'b1;
      end else if (~|hist_next) begin
        btn_level <= 1'b0;
      end
    end
  end

  // previous debounced level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= btn_level;
    end
  end

  assign step_press = btn_level & ~level_q;

endmodule

// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - run/single-step/halt controller generating the processor clock-enable
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DB_DEPTH = DB_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_div,
  input  logic             mode_run,
  input  logic             step_btn,
  input  logic             halt_in,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] en_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic        rst_meta;
  logic        rst_int_n;
  logic        clk_div_q;
  logic        tick;
  logic        step_press;
  exec_state_t state_q;
  exec_state_t state_d;
  logic        cpu_en_d;

  // reset bridge: assertion passes straight through, release waits two clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta  <= 1'b0;
      rst_int_n <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_int_n <= rst_meta;
    end
  end

  // registered copy of the divider output; tick marks its rising edge only
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      clk_div_q <= 1'b0;
    end else begin
      clk_div_q <= clk_div;
    end
  end

  assign tick = clk_div & ~clk_div_q;

  btn_debounce #(
    .DB_DEPTH (DB_DEPTH)
  ) u_btn_debounce (
    .clk        (clk),
    .rst_n      (rst_int_n),
    .tick       (tick),
    .step_btn   (step_btn),
    .step_press (step_press)
  );

  // next state and enable request; halt beats every other event including a tick
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (halt_in) begin
          state_d = ST_HALTED;
        end else if (mode_run) begin
          state_d = ST_RUN;
        end else if (step_press) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_in) begin
          state_d = ST_HALTED;
        end else if (!mode_run) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          cpu_en_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (halt_in) begin
          state_d = ST_HALTED;
        end else if (tick) begin
          cpu_en_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (!halt_in && !mode_run) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state register and registered enable pulse
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
      cpu_en  <= 1'b0;
    end else begin
      state_q <= state_d;
      cpu_en  <= cpu_en_d;
    end
  end

  // count issued enables, wrapping naturally at the counter width
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      en_count <= '0;
    end else if (cpu_en) begin
      en_count <= en_count + CNT_ONE;
    end
  end

  assign state = state_q;

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the enable-pulse counter.
REQ-002 Parameter DB_DEPTH, default 3, consecutive slow-tick samples required to accept a button level.
REQ-003 clk  input  1  system clock; also clocks the upstream divider; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 clk_div  input  1  divided toggle from the upstream divider, synchronous to clk.
REQ-006 mode_run  input  1  run switch level: 1 = free-run, 0 = single-step.
REQ-007 step_btn  input  1  raw, asynchronous single-step pushbutton.
REQ-008 halt_in  input  1  processor halt request, synchronous to clk.
REQ-009 cpu_en  output  1  processor clock-enable, one clk wide per executed step.
REQ-010 state  output  2  current FSM state code.
REQ-011 en_count  output  CNT_W  number of cpu_en pulses issued, modulo 2^CNT_W.

Function
REQ-012 tick SHALL be a one-clk pulse when clk_div is 1 and its registered copy is 0 (rising edge only; falling edges ignored).
REQ-013 step_btn SHALL pass through a 2-flop synchroniser before any use.
REQ-014 On each tick the synchronised button SHALL shift into a DB_DEPTH history; debounced level becomes 1 on all-ones, 0 on all-zeros, else holds.
REQ-015 step_press SHALL be a one-clk pulse on a 0->1 transition of the debounced level.
REQ-016 States: IDLE=0, RUN=1, STEP=2, HALTED=3.
REQ-017 IDLE: halt_in -> HALTED; else mode_run -> RUN; else step_press -> STEP; else stay.
REQ-018 RUN: halt_in -> HALTED; else mode_run=0 -> IDLE; else each tick issues cpu_en.
REQ-019 STEP: halt_in -> HALTED; else first tick issues cpu_en and returns to IDLE.
REQ-020 HALTED: cpu_en held 0; exit to IDLE only when halt_in=0 and mode_run=0.
REQ-021 halt_in SHALL have priority over every other event, including a same-cycle tick (no cpu_en issued).
REQ-022 cpu_en SHALL be registered: tick in cycle N -> cpu_en=1 in cycle N+1 only.
REQ-023 step_press outside IDLE SHALL be discarded, not queued.
REQ-024 en_count SHALL increment in the cycle cpu_en is 1 and wrap from all-ones to 0.
REQ-025 mode_run changes SHALL take effect on the next clk, never cutting an already-registered cpu_en pulse.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, cpu_en=0, en_count=0, debounce history and level=0, synchroniser and clk_div copy=0.
REQ-027 Reset mid-RUN or mid-STEP SHALL drop any pending pulse; first cpu_en after release requires a fresh tick.
REQ-028 Reset release SHALL be synchronised internally (async assert, sync deassert).

Structure
REQ-029 State encodings and default DB_DEPTH SHALL live in shared package exec_pkg.
REQ-030 Synchroniser, history and press detection SHALL form sub-module btn_debounce, instantiated once.

Verification
(clk_div toggles every 4 clk, so one tick per 8 clk.)
REQ-031 mode_run=1 for 80 clk -> 10 cpu_en pulses, each 1 clk wide, each one cycle after a tick; en_count=10.
REQ-032 mode_run=0, step_btn held high 30 ticks -> exactly 1 cpu_en; state goes 2 then 0; bounce 1-0-1 across ticks -> 0 pulses.
REQ-033 RUN, halt_in asserted in a tick cycle -> no cpu_en that cycle or after, state=3; halt_in=0 with mode_run=1 -> stays 3; mode_run=0 -> state=0.
REQ-034 CNT_W=4, 17 pulses -> en_count=1 after wrap.
REQ-035 rst_n pulled low between a tick and its cpu_en -> cpu_en never asserted, all outputs 0 immediately, state=0.
REQ-036 step_press during RUN, then mode_run=0 -> state=0, no extra cpu_en.
